// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: state encoding shared by the FIFO read-side drainer.
// Used by fifo_reader (FSM) and fifo_reader_output_stage.
package fifo_reader_pkg;

  localparam int STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE,
    TRANSFER,
    FLUSH,
    COMPLETE
  } state_e;

endpackage

// File: rtl/fifo_reader_output_stage.sv
// fifo_reader_output_stage: valid/ready register carrying {last, data}.
// FIFO_READER_SKID_EN selects a 2-entry skid buffer with registered space.
module fifo_reader_output_stage
  import fifo_reader_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         space_o,
  output logic         drained_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

`ifdef FIFO_READER_SKID_EN
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         full_q, full_d;
  logic         take;

  always_comb begin
    take   = (cnt_q != 2'd0) && ready_i;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_i, take})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data_i;
        else tail_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
    full_d = (cnt_d == 2'd2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Space comes only from a flop: no path from ready_i to the FIFO pop.
  assign space_o   = !full_q;
  assign valid_o   = (cnt_q != 2'd0);
  assign data_o    = head_q;
  assign drained_o = !push_i &&
    ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && ready_i));
`else
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (push_i) begin
      valid_d = 1'b1;
      data_d  = push_data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign space_o   = !valid_q || ready_i;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign drained_o = !push_i && (!valid_q || ready_i);
`endif

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a commanded word count from a FIFO onto a stream.
// FIFO_READER_SKID_EN swaps the output register for a skid buffer.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int LENGTH_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fifo_empty,
  output logic                    fifo_read_enable,
  input  logic [WIDTH-1:0]        fifo_read_data,
  input  logic                    start,
  input  logic [LENGTH_WIDTH-1:0] length,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last
);

  state_e                  state_q, state_d;
  logic [LENGTH_WIDTH-1:0] rem_q, rem_d;
  logic                    space;
  logic                    drained;
  logic                    pop;
  logic                    last;
  logic [WIDTH:0]          stage_data;

  assign last = (rem_q == LENGTH_WIDTH'(1));
  assign pop  = (state_q == TRANSFER) && !fifo_empty &&
                (rem_q != '0) && space;

  assign fifo_read_enable = pop;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == COMPLETE);
  assign out_last         = stage_data[WIDTH];
  assign out_data         = stage_data[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (pop) rem_d = rem_q - LENGTH_WIDTH'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = length;
          // Empty command passes through FLUSH so done lands two cycles out.
          state_d = (length != '0) ? TRANSFER : FLUSH;
        end
      end
      TRANSFER: if (pop && last) state_d = FLUSH;
      FLUSH:    if (drained) state_d = COMPLETE;
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  fifo_reader_output_stage #(
    .W (WIDTH + 1)
  ) u_out (
    .clock       (clock),
    .reset       (reset),
    .push_i      (pop),
    .push_data_i ({last, fifo_read_data}),
    .space_o     (space),
    .drained_o   (drained),
    .valid_o     (out_valid),
    .ready_i     (out_ready),
    .data_o      (stage_data)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: table-driven, hand-written and random checks of fifo_reader.
// Expected stream = FIFO write order, with last on every length-th word.
module tb_fifo_reader;

  localparam int WIDTH = 8;
  localparam int LW    = 8;
`ifdef FIFO_READER_SKID_EN
  localparam int STALL_POPS = 2;
`else
  localparam int STALL_POPS = 1;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             fifo_empty;
  logic             fifo_read_enable;
  logic [WIDTH-1:0] fifo_read_data;
  logic             start;
  logic [LW-1:0]    length;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  fifo_reader #(
    .WIDTH        (WIDTH),
    .LENGTH_WIDTH (LW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_data   (fifo_read_data),
    .start            (start),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last)
  );

  always #5 clock = ~clock;

  typedef struct {
    int len;
    int pre;
    int gap;
    bit rnd;
    int left;
  } vec_t;

  vec_t tbl[6];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] wr_pend[$];
  logic [WIDTH-1:0] stream[$];
  logic             pop_seen = 1'b0;

  bit active    = 1'b0;
  int cur_len   = 0;
  int pop_cnt   = 0;
  int hs_cnt    = 0;
  int exp_done  = -1;
  int done_cnt  = 0;
  int start_cyc = 0;
  int first_hs  = 0;
  int last_hs   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  // Model FIFO: pops observed at the previous negedge, then queued writes.
  task automatic step;
    @(posedge clock);
    #1;
    if (pop_seen && fq.size() > 0) void'(fq.pop_front());
    while (wr_pend.size() > 0) fq.push_back(wr_pend.pop_front());
    fifo_empty     = (fq.size() == 0);
    fifo_read_data = fifo_empty ? '0 : fq[0];
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    wr_pend.push_back(w);
    stream.push_back(w);
  endtask

  task automatic clear_fifo;
    fq.delete();
    stream.delete();
  endtask

  always @(negedge clock) begin
    pop_seen = fifo_read_enable;
    if (reset) begin
      active   = 1'b0;
      exp_done = -1;
    end else begin
      if (active && cyc > start_cyc) chk("busy", busy, 1);
      else if (!active) chk("idle_busy", busy, 0);
      if (out_valid)
        chk("valid_in_xfer", int'(active && hs_cnt < cur_len), 1);
      if (fifo_read_enable) begin
        pop_cnt++;
        chk("pop_in_xfer", active, 1);
        chk("pop_nonempty", fifo_empty, 0);
        chk("pop_le_len", int'(pop_cnt <= cur_len), 1);
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (hs_cnt == 1) first_hs = cyc;
        last_hs = cyc;
        chk("model_has_word", int'(stream.size() > 0), 1);
        if (stream.size() > 0) chk("out_data", out_data, stream.pop_front());
        chk("out_last", out_last, int'(hs_cnt == cur_len));
        if (hs_cnt == cur_len) exp_done = cyc + 1;
      end
      if (start && !active) begin
        active    = 1'b1;
        cur_len   = int'(length);
        pop_cnt   = 0;
        hs_cnt    = 0;
        start_cyc = cyc;
        exp_done  = (length == '0) ? cyc + 2 : -1;
      end
      if (done) begin
        chk("done_in_xfer", active, 1);
        chk("done_cycle", cyc, exp_done);
        chk("done_pops", pop_cnt, cur_len);
        chk("done_words", hs_cnt, cur_len);
        active = 1'b0;
        done_cnt++;
      end else if (active && cyc == exp_done) begin
        chk("done_missing", done, 1);
      end
    end
  end

  task automatic wait_done(input int d0, input int budget);
    int k;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      step;
      k++;
    end
  endtask

  task automatic run_xfer(input int len, input int pre, input int gap,
                          input bit rnd, input int left);
    int d0, need, fed, k;
    d0   = done_cnt;
    need = (gap > 0 && len > pre) ? len - pre : 0;
    fed  = 0;
    for (int i = 0; i < pre; i++) push_word(8'($urandom));
    out_ready = 1'b1;
    step;
    start  = 1'b1;
    length = LW'(len);
    step;
    start = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 20 * len + 40) begin
      out_ready = rnd ? 1'($urandom) : 1'b1;
      if (gap > 0 && fed < need && k % gap == 0) begin
        push_word(8'($urandom));
        fed++;
      end
      step;
      k++;
    end
    out_ready = 1'b1;
    step;
    step;
    chk("xfer_done_once", done_cnt - d0, 1);
    chk("fifo_leftover", fq.size(), left);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, k, lft, len, gap, pre, need;
    tbl[0] = '{len: 3, pre: 4,  gap: 0, rnd: 0, left: 1};
    tbl[1] = '{len: 4, pre: 0,  gap: 3, rnd: 0, left: 0};
    tbl[2] = '{len: 0, pre: 0,  gap: 0, rnd: 0, left: 0};
    tbl[3] = '{len: 1, pre: 1,  gap: 0, rnd: 0, left: 0};
    tbl[4] = '{len: 7, pre: 10, gap: 0, rnd: 1, left: 3};
    tbl[5] = '{len: 5, pre: 2,  gap: 2, rnd: 1, left: 0};

    reset          = 1'b1;
    start          = 1'b0;
    length         = '0;
    out_ready      = 1'b1;
    fifo_empty     = 1'b1;
    fifo_read_data = '0;
    step;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rden", fifo_read_enable, 0);
    step;
    reset = 1'b0;
    step;

    for (int i = 0; i < 6; i++) begin
      run_xfer(tbl[i].len, tbl[i].pre, tbl[i].gap, tbl[i].rnd, tbl[i].left);
      clear_fifo;
      step;
    end

    // Basic transfer with fixed data; 0x44 must stay behind.
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    run_xfer(3, 0, 0, 1'b0, 1);
    chk("basic_latency", first_hs - start_cyc, 2);
    chk("basic_back2back", last_hs - first_hs, 2);
    if (fq.size() > 0) chk("basic_left_word", fq[0], 8'h44);
    clear_fifo;
    step;

    // Consumer stall.
    push_word(8'h11);
    push_word(8'h22);
    step;
    d0        = done_cnt;
    out_ready = 1'b0;
    start     = 1'b1;
    length    = LW'(2);
    step;
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      step;
      k++;
    end
    chk("stall_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("stall_hold", out_data, 8'h11);
    end
    chk("stall_pops", pop_cnt, STALL_POPS);
    out_ready = 1'b1;
    wait_done(d0, 20);
    step;
    chk("stall_done", done_cnt - d0, 1);
    clear_fifo;
    step;

    // Start while busy, and start in the done cycle, are both ignored.
    for (int i = 0; i < 6; i++) push_word(8'($urandom));
    step;
    d0     = done_cnt;
    start  = 1'b1;
    length = LW'(3);
    step;
    start = 1'b0;
    step;
    start  = 1'b1;
    length = LW'(5);
    step;
    start = 1'b0;
    k = 0;
    while (!done && k < 30) begin
      step;
      k++;
    end
    start  = 1'b1;
    length = LW'(2);
    step;
    start = 1'b0;
    chk("complete_start_ignored", busy, 0);
    step;
    chk("busy_start_done", done_cnt - d0, 1);
    chk("busy_start_left", fq.size(), 3);
    clear_fifo;
    step;

    // Reset after two of five words.
    for (int i = 0; i < 6; i++) push_word(8'($urandom));
    step;
    d0     = done_cnt;
    start  = 1'b1;
    length = LW'(5);
    step;
    start = 1'b0;
    k = 0;
    while (hs_cnt < 2 && k < 20) begin
      step;
      k++;
    end
    reset = 1'b1;
    step;
    reset  = 1'b0;
    stream = fq;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_rden", fifo_read_enable, 0);
    step;
    step;
    step;
    chk("mid_rst_no_done", done_cnt - d0, 0);
    lft = (fq.size() > 0) ? fq.size() - 1 : 0;
    if (fq.size() == 0) push_word(8'h5a);
    run_xfer(1, 0, 0, 1'b0, lft);
    clear_fifo;
    step;

    // Full rate, 255 words.
    for (int i = 0; i < 260; i++) push_word(8'($urandom));
    run_xfer(255, 0, 0, 1'b0, 5);
    chk("full_rate_span", last_hs - first_hs, 254);
    clear_fifo;
    step;

    // Random commands, feeding and back-pressure.
    for (int it = 0; it < 15; it++) begin
      len = $urandom_range(0, 24);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        pre  = $urandom_range(0, len);
        need = (len > pre) ? len - pre : 0;
        lft  = pre + need - len;
      end else begin
        pre = len + $urandom_range(0, 3);
        lft = pre - len;
      end
      run_xfer(len, pre, gap, 1'b1, lft);
      clear_fifo;
      step;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
